// File: rtl/ir_burst_emitter.sv
// -----------------------------------------------------------------------------
// ir_burst_emitter
//
// Transmit side of the rover IR obstacle-sensing link. Drives two IR LEDs with
// bursts of a square-wave carrier separated by silent gaps. Bursts alternate
// between emitter 0 and emitter 1 so the receive path can tell which side
// produced a detection. A burst is never cut short by enable; only reset
// aborts one.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   enable         in   level; high requests continuous burst/gap operation
//   IR_leds        out  [1:0] LED drive, bit i = emitter i, at most one high
//   burst_active   out  high on every cycle of a burst
//   active_emitter out  emitter owning the current or most recent burst
//   burst_done     out  one-cycle pulse on the first gap cycle
//   burst_count    out  [7:0] completed bursts, wraps 255 -> 0
//
// Carrier half-period HALF = CLK_FREQ_HZ / (2*CARRIER_HZ) clocks (>= 1).
// A burst lasts BURST_CYCLES*2*HALF clocks, a gap GAP_CYCLES*2*HALF clocks.
// -----------------------------------------------------------------------------
module ir_burst_emitter #(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int CARRIER_HZ   = 38_000,
  parameter int BURST_CYCLES = 20,
  parameter int GAP_CYCLES   = 40
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  output logic [1:0] IR_leds,
  output logic       burst_active,
  output logic       active_emitter,
  output logic       burst_done,
  output logic [7:0] burst_count
);

  localparam int HALF    = CLK_FREQ_HZ / (2 * CARRIER_HZ);
  localparam int HALF_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int MAX_PER = (BURST_CYCLES > GAP_CYCLES) ? BURST_CYCLES : GAP_CYCLES;
  localparam int PER_W   = (MAX_PER > 1) ? $clog2(MAX_PER) : 1;

  localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(HALF - 1);
  localparam logic [PER_W-1:0]  BURST_LAST = PER_W'(BURST_CYCLES - 1);
  localparam logic [PER_W-1:0]  GAP_LAST   = PER_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Control state
  state_e              state_q, state_d;
  logic [HALF_W-1:0]   half_cnt_q, half_cnt_d;
  logic                phase_q, phase_d;       // 0 = carrier high half
  logic [PER_W-1:0]    period_cnt_q, period_cnt_d;
  logic                emitter_q, emitter_d;

  // Registered outputs
  logic [1:0]          leds_q, leds_d;
  logic                active_q, active_d;
  logic                done_q, done_d;
  logic [7:0]          count_q, count_d;

  // Timing decodes on the current cycle
  logic half_wrap;
  logic period_wrap;
  logic burst_end;
  logic gap_end;

  assign half_wrap   = (half_cnt_q == HALF_LAST);
  assign period_wrap = half_wrap && phase_q;
  assign burst_end   = period_wrap && (period_cnt_q == BURST_LAST);
  assign gap_end     = period_wrap && (period_cnt_q == GAP_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      half_cnt_q   <= '0;
      phase_q      <= 1'b0;
      period_cnt_q <= '0;
      emitter_q    <= 1'b0;
      leds_q       <= 2'b00;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
      count_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      half_cnt_q   <= half_cnt_d;
      phase_q      <= phase_d;
      period_cnt_q <= period_cnt_d;
      emitter_q    <= emitter_d;
      leds_q       <= leds_d;
      active_q     <= active_d;
      done_q       <= done_d;
      count_q      <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    half_cnt_d   = half_cnt_q;
    phase_d      = phase_q;
    period_cnt_d = period_cnt_q;
    emitter_d    = emitter_q;

    // Carrier timebase advance; overridden below when a state ends.
    if (state_q != IDLE) begin
      if (half_wrap) begin
        half_cnt_d = '0;
        phase_d    = ~phase_q;
        if (phase_q) begin
          period_cnt_d = period_cnt_q + PER_W'(1);
        end
      end else begin
        half_cnt_d = half_cnt_q + HALF_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = BURST;
          emitter_d = 1'b0;   // first burst out of IDLE is always emitter 0
        end
      end

      BURST: begin
        if (burst_end) begin
          state_d      = GAP;
          half_cnt_d   = '0;
          phase_d      = 1'b0;
          period_cnt_d = '0;
        end
      end

      GAP: begin
        if (gap_end) begin
          half_cnt_d   = '0;
          phase_d      = 1'b0;
          period_cnt_d = '0;
          if (enable) begin
            state_d   = BURST;
            emitter_d = ~emitter_q;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d      = IDLE;
        half_cnt_d   = '0;
        phase_d      = 1'b0;
        period_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: computed from the next state so the outputs are registered
  // alongside it and line up with the state they describe.
  // ---------------------------------------------------------------------------
  always_comb begin
    leds_d   = 2'b00;
    active_d = (state_d == BURST);
    done_d   = (state_q == BURST) && (state_d == GAP);
    count_d  = count_q;

    if ((state_d == BURST) && !phase_d) begin
      leds_d = emitter_d ? 2'b10 : 2'b01;
    end

    if (done_d) begin
      count_d = count_q + 8'd1;   // intentional 255 -> 0 wrap
    end
  end

  assign IR_leds        = leds_q;
  assign burst_active   = active_q;
  assign active_emitter = emitter_q;
  assign burst_done     = done_q;
  assign burst_count    = count_q;

endmodule

// File: tb/tb_ir_burst_emitter.sv
// -----------------------------------------------------------------------------
// tb_ir_burst_emitter
//
// Self-checking bench for ir_burst_emitter with HALF = 10, 3-period bursts and
// 2-period gaps: a burst is 60 clocks and a burst+gap frame is 100 clocks.
//
// Edge numbering: edge 0 is the first rising edge that samples enable high in
// IDLE. Values read just after edge k are the outputs for "cycle k+1".
// The reference model tracks only the position t inside the current frame, so
// every expected output is plain arithmetic on t.
// -----------------------------------------------------------------------------
module tb_ir_burst_emitter;

  localparam int CLK_FREQ_HZ  = 760;
  localparam int CARRIER_HZ   = 38;
  localparam int BURST_CYCLES = 3;
  localparam int GAP_CYCLES   = 2;

  localparam int HALF      = 10;                             // 760 / (2*38)
  localparam int BURST_LEN = BURST_CYCLES * 2 * HALF;        // 60
  localparam int FRAME     = BURST_LEN + GAP_CYCLES * 2 * HALF; // 100

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [1:0] IR_leds;
  logic       burst_active;
  logic       active_emitter;
  logic       burst_done;
  logic [7:0] burst_count;

  ir_burst_emitter #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .CARRIER_HZ  (CARRIER_HZ),
    .BURST_CYCLES(BURST_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .IR_leds       (IR_leds),
    .burst_active  (burst_active),
    .active_emitter(active_emitter),
    .burst_done    (burst_done),
    .burst_count   (burst_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int e = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: running flag, position in frame, emitter, burst count.
  // ---------------------------------------------------------------------------
  bit         m_run;
  int         m_t;
  bit         m_emit;
  logic [7:0] m_count;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_run   = 1'b0;
      m_t     = 0;
      m_emit  = 1'b0;
      m_count = 8'd0;
    end else if (!m_run) begin
      if (enable) begin
        m_run  = 1'b1;
        m_t    = 0;
        m_emit = 1'b0;
      end
    end else begin
      m_t++;
      if (m_t == BURST_LEN) m_count++;
      if (m_t == FRAME) begin
        if (enable) begin
          m_t    = 0;
          m_emit = ~m_emit;
        end else begin
          m_run = 1'b0;
          m_t   = 0;
        end
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clock) begin
    logic       exp_active;
    logic [1:0] exp_leds;
    logic       exp_done;
    exp_active = m_run && (m_t < BURST_LEN);
    exp_leds   = (exp_active && ((m_t % (2 * HALF)) < HALF))
                 ? (m_emit ? 2'b10 : 2'b01) : 2'b00;
    exp_done   = m_run && (m_t == BURST_LEN);
    check("model_leds",    IR_leds,        exp_leds);
    check("model_active",  burst_active,   exp_active);
    check("model_emitter", active_emitter, m_emit);
    check("model_done",    burst_done,     exp_done);
    check("model_count",   burst_count,    m_count);
    if (burst_done === 1'b1) done_seen++;
  end

  // Advance to just after edge `target`.
  task automatic adv_to(input int target);
    while (e < target) begin
      @(posedge clock);
      #1;
      e++;
    end
  endtask

  // Start a sequence: enable goes high, the next edge becomes edge 0.
  task automatic start_run();
    @(posedge clock);
    #1;
    enable = 1'b1;
    @(posedge clock);
    #1;
    e = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    #12;
    check("reset_leds",    IR_leds,        2'b00);
    check("reset_active",  burst_active,   1'b0);
    check("reset_emitter", active_emitter, 1'b0);
    check("reset_done",    burst_done,     1'b0);
    check("reset_count",   burst_count,    8'd0);
    #10;
    reset_n = 1'b1;

    // --- First burst and frame timing ---------------------------------------
    start_run();
    check("c1_leds",   IR_leds,      2'b01);
    check("c1_active", burst_active, 1'b1);
    adv_to(9);   check("c10_leds_high", IR_leds, 2'b01);
    adv_to(10);  check("c11_leds_low",  IR_leds, 2'b00);
    adv_to(20);  check("c21_leds_high", IR_leds, 2'b01);
    adv_to(59);
    check("c60_leds",   IR_leds,      2'b00);
    check("c60_active", burst_active, 1'b1);
    check("c60_done",   burst_done,   1'b0);
    adv_to(60);
    check("c61_done",    burst_done,     1'b1);
    check("c61_count",   burst_count,    8'd1);
    check("c61_active",  burst_active,   1'b0);
    check("c61_emitter", active_emitter, 1'b0);
    adv_to(61);  check("c62_done", burst_done, 1'b0);
    adv_to(99);
    check("c100_leds",   IR_leds,      2'b00);
    check("c100_active", burst_active, 1'b0);
    adv_to(100);
    check("c101_leds",    IR_leds,        2'b10);
    check("c101_emitter", active_emitter, 1'b1);

    // --- Alternation over four bursts, drop enable in the fourth ------------
    adv_to(200); check("b3_emitter", active_emitter, 1'b0);
    adv_to(300); check("b4_emitter", active_emitter, 1'b1);
    adv_to(330); enable = 1'b0;
    adv_to(361);
    check("b4_count",     burst_count, 8'd4);
    check("b4_done_seen", done_seen,   4);
    adv_to(400);
    check("idle_active",  burst_active,   1'b0);
    check("idle_leds",    IR_leds,        2'b00);
    check("idle_emitter", active_emitter, 1'b1);
    check("idle_count",   burst_count,    8'd4);

    // --- One-cycle enable pulse from IDLE restarts at emitter 0 -------------
    adv_to(410); enable = 1'b1;
    adv_to(411);
    enable = 1'b0;
    check("pulse_leds",    IR_leds,        2'b01);
    check("pulse_emitter", active_emitter, 1'b0);
    adv_to(471);
    check("pulse_done",  burst_done,  1'b1);
    check("pulse_count", burst_count, 8'd5);
    adv_to(511);
    check("pulse_idle_active", burst_active, 1'b0);
    check("pulse_idle_count",  burst_count,  8'd5);

    // --- Asynchronous reset mid-burst while the LED is high -----------------
    adv_to(520); enable = 1'b1;
    adv_to(563);
    check("pre_reset_leds", IR_leds, 2'b01);
    enable = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_leds",    IR_leds,        2'b00);
    check("async_active",  burst_active,   1'b0);
    check("async_count",   burst_count,    8'd0);
    check("async_done",    burst_done,     1'b0);
    check("async_emitter", active_emitter, 1'b0);
    #3;
    reset_n = 1'b1;

    // --- 256 bursts: burst_count wraps on the 256th burst_done --------------
    start_run();
    adv_to(254 * FRAME + BURST_LEN);
    check("wrap255_done",  burst_done,  1'b1);
    check("wrap255_count", burst_count, 8'd255);
    adv_to(255 * FRAME + BURST_LEN);
    check("wrap0_done",    burst_done,     1'b1);
    check("wrap0_count",   burst_count,    8'd0);
    check("wrap0_emitter", active_emitter, 1'b1);
    enable = 1'b0;
    adv_to(256 * FRAME + 5);
    check("final_idle", burst_active, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_burst_emitter.md
Name: ir_burst_emitter

Overview:
- Transmit side of the rover IR obstacle-sensing link. Drives the two IR LEDs with bursts of a modulated carrier (38 kHz by default), separated by silent gaps.
- Bursts alternate between emitter 0 and emitter 1, so the IR receive path can attribute a detection to one side.
- Sits beside the IR sensor receiver. Its burst/emitter status outputs let downstream logic qualify detections.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- CARRIER_HZ, 38_000, carrier frequency. HALF = CLK_FREQ_HZ/(2*CARRIER_HZ), integer-truncated; must be >=1. Carrier period = 2*HALF clocks.
- BURST_CYCLES, 20, carrier periods per burst; must be >=1.
- GAP_CYCLES, 40, carrier periods of silence after each burst; must be >=1.

Ports:
- clock  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; high requests continuous burst/gap operation.
- IR_leds  out  2  active-high LED drive; bit i = emitter i. At most one bit is ever high.
- burst_active  out  1  high for every cycle of the BURST state.
- active_emitter  out  1  index of the emitter owning the current or most recent burst.
- burst_done  out  1  one-cycle pulse on the first cycle of each GAP.
- burst_count  out  8  completed-burst counter; wraps 255->0.

Behaviour:
- All outputs registered. Reset (async assert, reset_n low): state=IDLE, IR_leds=0, burst_active=0, active_emitter=0, burst_done=0, burst_count=0, all internal counters=0. Reset takes effect immediately, including mid-burst; LEDs go low with no completion.
- Internal counters: half_cnt counts 0..HALF-1; phase toggles when half_cnt wraps; period_cnt counts completed carrier periods.

State IDLE:
- Outputs low; counters held at 0.
- enable sampled high at edge N -> BURST from N+1, emitter 0 (first burst after reset or after IDLE is always emitter 0).

State BURST:
- IR_leds[active_emitter] = 1 while phase=0, 0 while phase=1. Each burst starts with the high half.
- Lasts exactly BURST_CYCLES*2*HALF clocks.
- On the final clock -> GAP. On the GAP entry cycle: burst_done=1 and burst_count increments.

State GAP:
- IR_leds=0, burst_active=0. Lasts exactly GAP_CYCLES*2*HALF clocks.
- At end: if enable=1 -> BURST with active_emitter toggled; otherwise -> IDLE.

enable handling:
- Only sampled in IDLE and at the last GAP cycle.
- Deasserting enable mid-burst does not truncate the burst; the burst and its gap complete, then the block goes to IDLE. Truncated bursts are forbidden.

Other rules:
- burst_done and the burst_count increment occur on the same edge.
- active_emitter holds its value through GAP and IDLE until the next burst starts.
- Counters are sized by $clog2 of their max counts. No arithmetic overflow apart from the intentional burst_count wrap.

Test Plan (bench params CLK_FREQ_HZ=760, CARRIER_HZ=38 -> HALF=10; BURST_CYCLES=3; GAP_CYCLES=2):
- Reset then enable=1 at edge 0 -> from cycle 1, IR_leds=01 toggling 10 high/10 low for 60 clocks, burst_active=1. burst_done pulses at cycle 61; IR_leds=00 for 40 clocks; at cycle 101 IR_leds=10 (emitter 1), active_emitter=1.
- Hold enable=1 for 4 bursts -> emitter sequence 0,1,0,1; burst_count=4; exactly 4 single-cycle burst_done pulses spaced 100 clocks apart; IR_leds never 11.
- Drop enable at cycle 30 (mid-burst) -> burst runs to cycle 60, gap to 100, then IDLE with outputs 0; burst_count=1. Re-enable -> next burst uses emitter 0.
- Assert reset_n=0 at cycle 45 (mid-burst, LED high) -> IR_leds=00, burst_count=0, state IDLE immediately, without waiting for a clock edge.
- Run 256 bursts -> burst_count wraps to 0 on the 256th burst_done.
- Pulse enable high for 1 cycle only -> one full burst and one gap occur, then IDLE; burst_count=1.
